// File: rtl/sdram_test_sequencer.sv
// sdram_test_sequencer: write / read-back / compare memory test driving the SDRAM controller host port.
// Latency: 1 cycle per written word, 2 cycles per read word (issue + data) with an always-ready controller.
// Backpressure: command held stable until ctl_cmd_ready; single read outstanding, bounded by TIMEOUT_CYC. Define SDRAM_TEST_LFSR_EN for LFSR data.
module sdram_test_sequencer #(
   parameter int ADDR_W      = 23,
   parameter int DATA_W      = 16,
   parameter int LAST_ADDR   = 2**23-1,
   parameter int NUM_PASSES  = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              sys_clk,
   input  logic              sys_reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_data,
   output logic              ctl_cmd_valid,
   input  logic              ctl_cmd_ready,
   output logic              ctl_cmd_we,
   output logic [ADDR_W-1:0] ctl_addr,
   output logic [DATA_W-1:0] ctl_wdata,
   input  logic              ctl_rdata_valid,
   input  logic [DATA_W-1:0] ctl_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT_RD, S_NEXT, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(LAST_ADDR);
   localparam logic [7:0]        LAST_PASS = 8'(NUM_PASSES - 1);
   localparam logic [15:0]       TO_LAST   = 16'(TIMEOUT_CYC - 1);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        pass_n;
   logic [15:0]       timer;
   logic [DATA_W-1:0] cur_pat;
   logic [DATA_W-1:0] exp_word;
   logic              xfer;
   logic              at_last;

   assign xfer    = ctl_cmd_valid && ctl_cmd_ready;
   assign at_last = (addr == LAST);

`ifdef SDRAM_TEST_LFSR_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   logic [15:0] lfsr;
   logic        lfsr_reload;
   logic        lfsr_adv;

   assign lfsr_reload = (state == S_IDLE && start) || (state == S_WRITE && xfer && at_last) ||
                        (state == S_NEXT && pass_n != LAST_PASS);
   assign lfsr_adv    = (state == S_WRITE && xfer && !at_last) || (state == S_WAIT_RD && ctl_rdata_valid);

   // Reseed at the head of every write and read phase, step once per word consumed
   always_ff @(posedge sys_clk) begin
      if (sys_reset)
         lfsr <= 16'h0;
      else if (lfsr_reload)
         lfsr <= LFSR_SEED;
      else if (lfsr_adv)
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   assign cur_pat = lfsr;
`else
   // Low 16 address bits with the upper address bits folded into the top of the word
   function automatic logic [DATA_W-1:0] addr_pat(input logic [ADDR_W-1:0] a);
      logic [22:0] aw;
      logic [15:0] p;
      aw = 23'(a);
      p  = aw[15:0] ^ {aw[22:16], 9'b0};
      return DATA_W'(p);
   endfunction

   assign cur_pat = addr_pat(addr);
`endif

   // Odd passes use the inverted pattern so every bit is exercised both ways
   assign exp_word  = pass_n[0] ? ~cur_pat : cur_pat;
   assign ctl_addr  = addr;
   assign ctl_wdata = ctl_cmd_we ? exp_word : '0;

   // Test sequencer: command issue, read-back compare, status capture
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state          <= S_IDLE;
         addr           <= '0;
         pass_n         <= 8'd0;
         timer          <= 16'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         err_count      <= 16'd0;
         first_err_addr <= '0;
         first_err_data <= '0;
         ctl_cmd_valid  <= 1'b0;
         ctl_cmd_we     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  err_count      <= 16'd0;
                  first_err_addr <= '0;
                  first_err_data <= '0;
                  timeout        <= 1'b0;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  pass_n         <= 8'd0;
                  addr           <= '0;
                  busy           <= 1'b1;
                  ctl_cmd_valid  <= 1'b1;
                  ctl_cmd_we     <= 1'b1;
                  state          <= S_WRITE;
               end
            end
            S_WRITE: begin
               // valid stays high: the next write (or first read) follows back to back
               if (xfer) begin
                  if (at_last) begin
                     addr       <= '0;
                     ctl_cmd_we <= 1'b0;
                     state      <= S_READ;
                  end else begin
                     addr <= addr + ADDR_W'(1);
                  end
               end
            end
            S_READ: begin
               if (ctl_cmd_ready) begin
                  ctl_cmd_valid <= 1'b0;
                  timer         <= 16'd0;
                  state         <= S_WAIT_RD;
               end
            end
            S_WAIT_RD: begin
               if (ctl_rdata_valid) begin
                  if (ctl_rdata != exp_word) begin
                     if (err_count == 16'd0) begin
                        first_err_addr <= addr;
                        first_err_data <= ctl_rdata;
                     end
                     if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                  end
                  if (at_last) begin
                     state <= S_NEXT;
                  end else begin
                     addr          <= addr + ADDR_W'(1);
                     ctl_cmd_valid <= 1'b1;
                     state         <= S_READ;
                  end
               end else if (timer == TO_LAST) begin
                  timeout <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            S_NEXT: begin
               if (pass_n == LAST_PASS) begin
                  state <= S_DONE;
               end else begin
                  pass_n        <= pass_n + 8'd1;
                  addr          <= '0;
                  ctl_cmd_valid <= 1'b1;
                  ctl_cmd_we    <= 1'b1;
                  state         <= S_WRITE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= (err_count == 16'd0) && !timeout;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_test_sequencer.sv
// Bench for sdram_test_sequencer: memory model responder, expected command stream and run status checks.
// Command stream is built from the pattern rules; responder returns read data one cycle after transfer.
// Runs: ideal, bit-flip fault, dropped read (timeout), ready stall, reset during read phase.
module tb_sdram_test_sequencer;

   localparam int AW    = 23;
   localparam int DW    = 16;
   localparam int LAST  = 15;
   localparam int NP    = 2;
   localparam int TO    = 255;
   localparam int NWORD = LAST + 1;
   localparam int NCMD  = 2 * NWORD * NP;

   logic          sys_clk = 1'b0;
   logic          sys_reset = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, pass, timeout;
   logic [15:0]   err_count;
   logic [AW-1:0] first_err_addr;
   logic [DW-1:0] first_err_data;
   logic          ctl_cmd_valid;
   logic          ctl_cmd_ready = 1'b0;
   logic          ctl_cmd_we;
   logic [AW-1:0] ctl_addr;
   logic [DW-1:0] ctl_wdata;
   logic          ctl_rdata_valid = 1'b0;
   logic [DW-1:0] ctl_rdata = '0;

   sdram_test_sequencer #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LAST), .NUM_PASSES(NP), .TIMEOUT_CYC(TO)) dut (
      .sys_clk(sys_clk), .sys_reset(sys_reset), .start(start), .busy(busy), .done(done), .pass(pass),
      .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr), .first_err_data(first_err_data),
      .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd_ready(ctl_cmd_ready), .ctl_cmd_we(ctl_cmd_we), .ctl_addr(ctl_addr),
      .ctl_wdata(ctl_wdata), .ctl_rdata_valid(ctl_rdata_valid), .ctl_rdata(ctl_rdata)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int failures = 0;

   // expected command stream for one complete run
   logic          exp_we   [NCMD];
   logic [AW-1:0] exp_addr [NCMD];
   logic [DW-1:0] exp_dat  [NCMD];

   // run configuration (written by the sequencing process only)
   int mode = 0;        // 0 ideal, 1 flip bit0 at addr 5 pass 0, 2 drop read of addr 3 pass 0
   bit stall_en = 1'b0;

   // responder / model state (written by the responder process only)
   int            idx = 0, wr_cnt = 0, rd_cnt = 0, cyc = 0, drop_cyc = 0, stall_cnt = 0;
   bit            rd_pend = 1'b0;
   logic [AW-1:0] pend_addr = '0;
   int            pend_k = 0;
   int            mdl_err = 0;
   logic [AW-1:0] mdl_fa = '0;
   logic [DW-1:0] mdl_fd = '0;
   logic [DW-1:0] mem [NWORD];
   logic [DW-1:0] wd_first0 = '0, wd_first1 = '0;
   logic [40:0]   prev_cmd = '0;
   bit            prev_valid = 1'b0, prev_ready = 1'b0, prev_rd_xfer = 1'b0, prev_busy = 1'b0, prev_timeout = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   task automatic tick();
      @(negedge sys_clk);
      #2;
   endtask

   // Responder and per-cycle compare process, acting on the falling edge
   initial begin
      logic [DW-1:0] d;
      forever begin
         @(negedge sys_clk);
         cyc++;
         if (sys_reset) begin
            chk("reset_flags", 64'({busy, done, pass, timeout, ctl_cmd_valid, ctl_cmd_we}), 64'd0);
            chk("reset_addrs", 64'({first_err_addr, ctl_addr}), 64'd0);
            chk("reset_data", 64'({err_count, first_err_data, ctl_wdata}), 64'd0);
            idx = 0; rd_pend = 1'b0; stall_cnt = 0;
            ctl_rdata_valid = 1'b0; ctl_cmd_ready = 1'b0;
            prev_valid = 1'b0; prev_rd_xfer = 1'b0; prev_busy = 1'b0; prev_timeout = 1'b0;
         end else begin
            if (busy && !prev_busy) begin
               idx = 0; wr_cnt = 0; rd_cnt = 0; mdl_err = 0; mdl_fa = '0; mdl_fd = '0;
            end
            if (prev_valid && !prev_ready)
               chk("cmd_hold", 64'({ctl_cmd_valid, ctl_cmd_we, ctl_addr, ctl_wdata}), 64'(prev_cmd));
            if (prev_rd_xfer)
               chk("valid_drop_after_read", 64'(ctl_cmd_valid), 64'd0);
            // read data one cycle after the read transfer
            ctl_rdata_valid = 1'b0;
            if (rd_pend) begin
               rd_pend = 1'b0;
               d = mem[pend_addr[3:0]];
               if (mode == 1 && pend_addr == AW'(5) && pend_k < NCMD / 2)
                  d = d ^ DW'(1);
               ctl_rdata_valid = 1'b1;
               ctl_rdata = d;
               if (d !== exp_dat[pend_k]) begin
                  if (mdl_err == 0) begin
                     mdl_fa = pend_addr;
                     mdl_fd = d;
                  end
                  mdl_err++;
               end
            end
            ctl_cmd_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            if (ctl_cmd_valid) begin
               if (idx >= NCMD) begin
                  chk("cmd_index", 64'(idx), 64'(NCMD - 1));
               end else begin
                  chk("cmd_we", 64'(ctl_cmd_we), 64'(exp_we[idx]));
                  chk("cmd_addr", 64'(ctl_addr), 64'(exp_addr[idx]));
                  if (exp_we[idx])
                     chk("cmd_wdata", 64'(ctl_wdata), 64'(exp_dat[idx]));
                  if (ctl_cmd_ready) begin
                     if (ctl_cmd_we) begin
                        mem[ctl_addr[3:0]] = ctl_wdata;
                        wr_cnt++;
                        if (idx == 0) wd_first0 = ctl_wdata;
                        if (idx == NCMD / 2) wd_first1 = ctl_wdata;
                        if (stall_en && idx == 7) stall_cnt = 10;
                     end else begin
                        rd_cnt++;
                        if (mode == 2 && ctl_addr == AW'(3) && idx < NCMD / 2) begin
                           drop_cyc = cyc;
                        end else begin
                           rd_pend = 1'b1;
                           pend_addr = ctl_addr;
                           pend_k = idx;
                        end
                     end
                     idx++;
                  end
               end
            end
            if (timeout && !prev_timeout)
               chk("timeout_latency", 64'(cyc - drop_cyc), 64'(TO + 1));
            prev_rd_xfer = ctl_cmd_valid && ctl_cmd_ready && !ctl_cmd_we;
            prev_valid = ctl_cmd_valid;
            prev_ready = ctl_cmd_ready;
            prev_cmd = {ctl_cmd_valid, ctl_cmd_we, ctl_addr, ctl_wdata};
            prev_busy = busy;
            prev_timeout = timeout;
         end
      end
   end

   task automatic launch(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy_after_start"}, 64'({busy, done}), 64'b10);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 3000) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, 64'(done), 64'd1);
   endtask

   task automatic check_status(input string tag, input logic ep, input logic eto, input int eerr,
                               input int efa, input int efd, input int ewr, input int erd);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_pass"}, 64'(pass), 64'(ep));
      chk({tag, "_timeout"}, 64'(timeout), 64'(eto));
      chk({tag, "_err_count"}, 64'(err_count), 64'(eerr));
      chk({tag, "_first_err_addr"}, 64'(first_err_addr), 64'(efa));
      chk({tag, "_first_err_data"}, 64'(first_err_data), 64'(efd));
      chk({tag, "_writes"}, 64'(wr_cnt), 64'(ewr));
      chk({tag, "_reads"}, 64'(rd_cnt), 64'(erd));
      chk({tag, "_err_vs_model"}, 64'(err_count), 64'(mdl_err));
      chk({tag, "_addr_vs_model"}, 64'(first_err_addr), 64'(mdl_fa));
      chk({tag, "_data_vs_model"}, 64'(first_err_data), 64'(mdl_fd));
   endtask

   // Watchdog: the run must never hang
   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   // Sequencing process: build expected stream, then the directed runs
   initial begin
      int k;
      logic [15:0] l;
      logic [DW-1:0] v;
      int fault_data;
      k = 0;
      for (int p = 0; p < NP; p++) begin
         for (int ph = 0; ph < 2; ph++) begin
            l = 16'hACE1;
            for (int a = 0; a < NWORD; a++) begin
`ifdef SDRAM_TEST_LFSR_EN
               v = l;
               l = lfsr_next(l);
`else
               v = 16'(a) ^ {7'(a >>> 16), 9'b0};
`endif
               if (p % 2 == 1) v = ~v;
               exp_we[k] = (ph == 0);
               exp_addr[k] = AW'(a);
               exp_dat[k] = v;
               k++;
            end
         end
      end
`ifdef SDRAM_TEST_LFSR_EN
      fault_data = int'(exp_dat[5] ^ 16'h0001);
`else
      fault_data = 32'h0004;
`endif

      sys_reset = 1'b1;
      repeat (3) tick();
      sys_reset = 1'b0;
      tick();

      // ideal controller, with a start pulse while busy that must be ignored
      mode = 0;
      launch("ideal");
      repeat (20) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("ideal");
      check_status("ideal", 1'b1, 1'b0, 0, 0, 0, 32, 32);
`ifdef SDRAM_TEST_LFSR_EN
      chk("first_wdata_pass0", 64'(wd_first0), 64'h0000ACE1);
      chk("first_wdata_pass1", 64'(wd_first1), 64'h0000531E);
`else
      chk("first_wdata_pass0", 64'(wd_first0), 64'h00000000);
      chk("first_wdata_pass1", 64'(wd_first1), 64'h0000FFFF);
`endif
      repeat (3) tick();
      chk("done_held", 64'({done, busy, pass}), 64'b101);

      // single bit flip on the pass-0 read of address 5
      mode = 1;
      launch("fault");
      wait_done("fault");
      check_status("fault", 1'b0, 1'b0, 1, 5, fault_data, 32, 32);

      // read of address 3 never answered
      mode = 2;
      launch("tmo");
      wait_done("tmo");
      check_status("tmo", 1'b0, 1'b1, 0, 0, 0, 16, 4);

      // ready withheld for 10 cycles in the middle of the write phase
      mode = 0;
      stall_en = 1'b1;
      launch("stall");
      wait_done("stall");
      check_status("stall", 1'b1, 1'b0, 0, 0, 0, 32, 32);
      stall_en = 1'b0;

      // reset in the read phase, then a clean run
      launch("abort");
      for (int i = 0; i < 500 && rd_cnt < 4; i++) tick();
      chk("abort_reached_read", 64'(rd_cnt >= 4), 64'd1);
      sys_reset = 1'b1;
      tick();
      sys_reset = 1'b0;
      tick();
      chk("abort_idle", 64'({busy, done, ctl_cmd_valid}), 64'd0);
      launch("rerun");
      wait_done("rerun");
      check_status("rerun", 1'b1, 1'b0, 0, 0, 0, 32, 32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
